// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding and sizing helpers
// shared by the NxN systolic AXIS engine and its PEs.
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_e;

  localparam int MAX_W = 128;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Extend a pw-bit product; callers truncate to the accumulator width.
  function automatic logic [MAX_W-1:0] acc_ext(
    input logic [MAX_W-1:0] p,
    input int               pw,
    input logic             sgn
  );
    logic [MAX_W-1:0] hi;
    hi = {MAX_W{1'b1}} << pw;
    return (sgn && p[7'(pw - 1)]) ? (p | hi) : (p & ~hi);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary MAC cell with registered
// east/south operand pass-through and clear/hold controls.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] a_q, b_q;
  logic [ACC_W-1:0]  acc_q, acc_d, ext;
  logic [PW-1:0]     prod;

  if (SIGNED != 0) begin : g_sgn
    assign prod = PW'($signed(a_i)) * PW'($signed(b_i));
  end else begin : g_uns
    assign prod = PW'(a_i) * PW'(b_i);
  end

  assign ext = ACC_W'(acc_ext(MAX_W'(prod), PW, SIGNED != 0));

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = ext;
    end else if (en_i) begin
      acc_d = acc_q + ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_nxn_axis_engine.sv
// systolic_nxn_axis_engine: AXIS operand loader, skewed feeder,
// FSM and row-major drain around an NxN output-stationary grid.
module systolic_nxn_axis_engine
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  input  logic [N*DATA_W-1:0] s_axis_data,
  input  logic                s_axis_valid,
  input  logic                s_axis_last,
  output logic                s_axis_ready,
  output logic [ACC_W-1:0]    m_axis_data,
  output logic                m_axis_valid,
  output logic                m_axis_last,
  input  logic                m_axis_ready,
  input  logic                i_acc_mode,
  output logic                o_busy,
  output logic                o_err,
  output logic                o_intr
);

  localparam int CW = cnt_w(2 * N);
  localparam int KW = cnt_w(3 * N);
  localparam int DW = cnt_w(N * N);
  localparam int IW = cnt_w(N);

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [KW-1:0] k_q;
  logic [DW-1:0] idx_q;
  logic          mode_q, err_q;

  logic [N-1:0][DATA_W-1:0] a_q [N];
  logic [N-1:0][DATA_W-1:0] b_q [N];

  logic          s_hs, m_hs, last_beat, frame_err;
  logic          k_end, d_end, pe_en, pe_clr;
  logic [IW-1:0] row_sel;

  assign s_hs      = s_axis_valid && s_axis_ready;
  assign m_hs      = m_axis_valid && m_axis_ready;
  assign last_beat = cnt_q == CW'(2 * N - 1);
  assign frame_err = s_hs && (s_axis_last != last_beat);
  assign k_end     = k_q == KW'(3 * N - 2);
  assign d_end     = idx_q == DW'(N * N - 1);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) state_q <= LOAD_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_A: begin
        if (frame_err)                       state_d = LOAD_A;
        else if (s_hs && cnt_q == CW'(N - 1)) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (frame_err)              state_d = LOAD_A;
        else if (s_hs && last_beat) state_d = COMPUTE;
      end
      COMPUTE: if (k_end) state_d = DRAIN;
      DRAIN:   if (m_hs && d_end) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_comb begin
    s_axis_ready = 1'b0;
    m_axis_valid = 1'b0;
    unique case (state_q)
      LOAD_A, LOAD_B: s_axis_ready = 1'b1;
      DRAIN:          m_axis_valid = 1'b1;
      default: ;
    endcase
  end

  assign m_axis_last = m_axis_valid && d_end;
  assign o_intr      = m_hs && d_end;
  assign o_busy      = !(state_q == LOAD_A && cnt_q == '0);
  assign o_err       = err_q;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      cnt_q  <= '0;
      k_q    <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (s_hs) cnt_q <= (frame_err || last_beat) ? '0 : cnt_q + 1'b1;
      k_q <= (state_q == COMPUTE) ? k_q + 1'b1 : '0;
      if (state_q != DRAIN) idx_q <= '0;
      else if (m_hs)        idx_q <= d_end ? '0 : idx_q + 1'b1;
      if (s_hs && state_q == LOAD_A && cnt_q == '0) mode_q <= i_acc_mode;
      if (frame_err) err_q <= 1'b1;
    end
  end

  // Beats 0..N-1 are A rows, beats N..2N-1 are B columns.
  assign row_sel = (state_q == LOAD_A) ? IW'(cnt_q) : IW'(cnt_q - CW'(N));

  always_ff @(posedge axi_clk) begin
    if (s_hs && state_q == LOAD_A) a_q[row_sel] <= s_axis_data;
    if (s_hs && state_q == LOAD_B) b_q[row_sel] <= s_axis_data;
  end

  assign pe_en  = state_q == COMPUTE;
  assign pe_clr = pe_en && k_q == '0 && !mode_q;

  logic [DATA_W-1:0] west  [N];
  logic [DATA_W-1:0] north [N];
  logic [DATA_W-1:0] ah    [N][N];
  logic [DATA_W-1:0] bv    [N][N];
  logic [ACC_W-1:0]  acc_w [N*N];

  // Row/column i enters i cycles late; zeros outside the window.
  for (genvar i = 0; i < N; i++) begin : g_feed
    logic [KW-1:0] off;
    logic          on;
    assign off      = k_q - KW'(i);
    assign on       = pe_en && (k_q >= KW'(i)) && (off < KW'(N));
    assign west[i]  = on ? a_q[i][IW'(off)] : '0;
    assign north[i] = on ? b_q[i][IW'(off)] : '0;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in, b_in;
      if (j == 0) begin : g_aw
        assign a_in = west[i];
      end else begin : g_an
        assign a_in = ah[i][j-1];
      end
      if (i == 0) begin : g_bn
        assign b_in = north[j];
      end else begin : g_bs
        assign b_in = bv[i-1][j];
      end
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk_i (axi_clk),
        .rst_i (axi_rst),
        .en_i  (pe_en),
        .clr_i (pe_clr),
        .a_i   (a_in),
        .b_i   (b_in),
        .a_o   (ah[i][j]),
        .b_o   (bv[i][j]),
        .acc_o (acc_w[i*N+j])
      );
    end
  end

  assign m_axis_data = acc_w[idx_q];

endmodule

// File: tb/tb_systolic_nxn_axis_engine.sv
// tb_systolic_nxn_axis_engine: directed vector table, random frames,
// framing errors and mid-drain reset on signed and unsigned 4x4 engines.
module tb_systolic_nxn_axis_engine;

  typedef logic [15:0][7:0]  mat8_t;
  typedef logic [15:0][31:0] mat32_t;

  typedef struct packed {
    mat8_t  a;
    mat8_t  b;
    logic   mode;
    logic   stall;
    mat32_t e;
    mat32_t eu;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        acc_mode = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid, m_last, busy, err, intr;
  logic [31:0] m_data;
  logic        u_s_ready, u_m_valid, u_m_last, u_busy, u_err, u_intr;
  logic [31:0] u_m_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic err_exp = 1'b0;

  mat32_t prev_s, prev_u, m_s, m_u;
  vec_t   tv [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_nxn_axis_engine #(
    .N(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)
  ) dut (
    .axi_clk(clk), .axi_rst(rst),
    .s_axis_data(s_data), .s_axis_valid(s_valid),
    .s_axis_last(s_last), .s_axis_ready(s_ready),
    .m_axis_data(m_data), .m_axis_valid(m_valid),
    .m_axis_last(m_last), .m_axis_ready(m_ready),
    .i_acc_mode(acc_mode), .o_busy(busy),
    .o_err(err), .o_intr(intr)
  );

  systolic_nxn_axis_engine #(
    .N(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)
  ) dut_u (
    .axi_clk(clk), .axi_rst(rst),
    .s_axis_data(s_data), .s_axis_valid(s_valid),
    .s_axis_last(s_last), .s_axis_ready(u_s_ready),
    .m_axis_data(u_m_data), .m_axis_valid(u_m_valid),
    .m_axis_last(u_m_last), .m_axis_ready(m_ready),
    .i_acc_mode(acc_mode), .o_busy(u_busy),
    .o_err(u_err), .o_intr(u_intr)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input mat8_t a, input mat8_t b, input bit mode);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [31:0] s, u;
        s = mode ? prev_s[i*4+j] : 32'd0;
        u = mode ? prev_u[i*4+j] : 32'd0;
        for (int k = 0; k < 4; k++) begin
          s = s + 32'(int'($signed(a[i*4+k])) * int'($signed(b[k*4+j])));
          u = u + 32'(int'(a[i*4+k]) * int'(b[k*4+j]));
        end
        m_s[i*4+j] = s;
        m_u[i*4+j] = u;
      end
    end
  endtask

  task automatic rand_mat(output mat8_t a, output mat8_t b);
    for (int k = 0; k < 16; k++) begin
      a[k] = 8'($urandom);
      b[k] = 8'($urandom);
    end
  endtask

  task automatic send_frame(input mat8_t a, input mat8_t b, input bit mode,
                            input int bad_last, output int t_last);
    t_last = 0;
    for (int bt = 0; bt < 8; bt++) begin
      int w;
      for (int k = 0; k < 4; k++)
        s_data[k*8 +: 8] = (bt < 4) ? a[bt*4+k] : b[k*4+bt-4];
      s_valid  = 1'b1;
      s_last   = (bad_last >= 0) ? (bt == bad_last) : (bt == 7);
      acc_mode = mode;
      w = 0;
      while (!s_ready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 100) chk("s_ready_timeout", s_ready, 1);
      t_last = cyc;
      @(posedge clk); #1;
      if (bt == bad_last) break;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic collect(input mat32_t e, input mat32_t eu, input bit stall,
                         input int t_last, input int nb);
    int beat, w, nint, first, ph;
    beat = 0; w = 0; nint = 0; first = -1; ph = 0;
    while (beat < nb && w < 300) begin
      m_ready = stall ? (ph % 3 != 2) : 1'b1;
      ph++;
      #1;
      if (intr) nint++;
      if (m_valid) begin
        if (first < 0) first = cyc;
        chk("data", m_data, e[beat]);
        chk("udata", u_m_data, eu[beat]);
        chk("last", m_last, beat == 15);
        if (m_ready) beat++;
      end
      @(posedge clk); #1;
      w++;
    end
    if (beat < nb) chk("drain_timeout", beat, nb);
    chk("latency", first - t_last, 12);
    if (nb == 16) begin
      chk("intr_count", nint, 1);
      chk("valid_after", m_valid, 0);
      chk("ready_after", s_ready, 1);
      chk("busy_after", busy, 0);
    end
    chk("err", err, err_exp);
  endtask

  task automatic no_output_window(input string nm);
    int nv;
    nv = 0;
    repeat (20) begin
      if (m_valid || u_m_valid) nv++;
      @(posedge clk); #1;
    end
    chk(nm, nv, 0);
    chk("ready_idle", s_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    mat8_t ra, rb;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int p;
        p = i * 4 + j;
        tv[0].a[p] = (i == j) ? 8'd1 : 8'd0;
        tv[0].b[p] = 8'(4 * i + j);
        tv[0].e[p] = 32'(4 * i + j);
        tv[0].eu[p] = 32'(4 * i + j);
        tv[1].a[p] = tv[0].a[p];
        tv[1].b[p] = tv[0].b[p];
        tv[1].e[p] = 32'(8 * i + 2 * j);
        tv[1].eu[p] = 32'(8 * i + 2 * j);
        tv[2].a[p] = 8'hFD;
        tv[2].b[p] = 8'd5;
        tv[2].e[p] = 32'hFFFF_FFC4;
        tv[2].eu[p] = 32'd5060;
        tv[3].a[p] = tv[0].a[p];
        tv[3].b[p] = tv[0].b[p];
        tv[3].e[p] = 32'(4 * i + j - 60);
        tv[3].eu[p] = 32'(5060 + 4 * i + j);
        tv[4].a[p] = 8'h7F;
        tv[4].b[p] = 8'h80;
        tv[4].e[p] = 32'hFFFF_0200;
        tv[4].eu[p] = 32'h0000_FE00;
      end
    end
    tv[0].mode = 1'b0; tv[0].stall = 1'b0;
    tv[1].mode = 1'b1; tv[1].stall = 1'b0;
    tv[2].mode = 1'b0; tv[2].stall = 1'b1;
    tv[3].mode = 1'b1; tv[3].stall = 1'b0;
    tv[4].mode = 1'b0; tv[4].stall = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_intr", intr, 0);
    prev_s = '0;
    prev_u = '0;

    for (int v = 0; v < 5; v++) begin
      model(tv[v].a, tv[v].b, tv[v].mode);
      send_frame(tv[v].a, tv[v].b, tv[v].mode, -1, t);
      chk("busy_compute", busy, 1);
      chk("ready_compute", s_ready, 0);
      s_valid = 1'b1;
      s_last  = 1'b1;
      collect(tv[v].e, tv[v].eu, tv[v].stall, t, 16);
      s_valid = 1'b0;
      s_last  = 1'b0;
      prev_s = m_s;
      prev_u = m_u;
    end

    for (int r = 0; r < 2; r++) begin
      rand_mat(ra, rb);
      model(ra, rb, r == 1);
      send_frame(ra, rb, r == 1, -1, t);
      collect(m_s, m_u, r == 0, t, 16);
      prev_s = m_s;
      prev_u = m_u;
    end

    send_frame(tv[0].a, tv[0].b, 1'b0, 3, t);
    chk("err_early_last", err, 1);
    err_exp = 1'b1;
    no_output_window("no_valid_early");
    rand_mat(ra, rb);
    model(ra, rb, 1'b1);
    send_frame(ra, rb, 1'b1, -1, t);
    collect(m_s, m_u, 1'b1, t, 16);
    prev_s = m_s;
    prev_u = m_u;

    send_frame(tv[2].a, tv[2].b, 1'b0, 99, t);
    chk("err_missing_last", err, 1);
    no_output_window("no_valid_missing");
    rand_mat(ra, rb);
    model(ra, rb, 1'b0);
    send_frame(ra, rb, 1'b0, -1, t);
    collect(m_s, m_u, 1'b0, t, 16);
    prev_s = m_s;
    prev_u = m_u;

    rand_mat(ra, rb);
    model(ra, rb, 1'b0);
    send_frame(ra, rb, 1'b0, -1, t);
    collect(m_s, m_u, 1'b0, t, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_ready", s_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    prev_s = '0;
    prev_u = '0;
    send_frame(tv[0].a, tv[0].b, 1'b1, -1, t);
    collect(tv[0].e, tv[0].eu, 1'b1, t, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
